// File: rtl/touch_adc_ctrl.sv
// touch_adc_ctrl: ADS7843-class touch ADC sequencer publishing 8-bit X/Y; define TOUCH_AVG_EN to publish 4-pair averages
module touch_adc_ctrl #(
    parameter int CLK_DIV    = 16,
    parameter int SETTLE_CYC = 4096,
    parameter int GAP_CYC    = 65536
) (
    input  logic       sys_clk,
    input  logic       iRST,
    input  logic       penirq_n,
    input  logic       adc_dout,
    output logic       adc_cs_n,
    output logic       adc_dclk,
    output logic       adc_din,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       new_coord_r,
    output logic       transmit_en
);
    localparam int CW = $clog2(SETTLE_CYC > GAP_CYC ? SETTLE_CYC : GAP_CYC) + 1;
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [5:0] PH_LAST = 6'd49;
    typedef enum logic [2:0] {IDLE, SETTLE, FRAME_Y, FRAME_X, UPDATE, GAP} state_t;
    state_t state_q, state_d;
    logic [1:0] pen_sync_q, dout_sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0] ph_q, ph_d;
    logic [11:0] res_q, res_d, raw_y_q, raw_y_d;
    logic cs_n_q, cs_n_d, dclk_q, dclk_d, din_q, din_d;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic new_q, new_d, tx_q, tx_d;
    logic pen_s, dout_s, half_end, frame_end, in_frame_d;
    logic [4:0] bit_d;
    logic [7:0] cmd_d;
`ifdef TOUCH_AVG_EN
    logic [13:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d, sum_x, sum_y;
    logic [1:0] pairs_q, pairs_d;
`endif
    assign pen_s = pen_sync_q[1];
    assign dout_s = dout_sync_q[1];
    // Frame phase: 0 lead-in, 1..48 DCLK halves (odd = high), 49 trailing cs_n-high half
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        div_d = div_q;
        ph_d = ph_q;
        res_d = res_q;
        raw_y_d = raw_y_q;
        x_d = x_q;
        y_d = y_q;
        new_d = 1'b0;
        tx_d = tx_q;
        half_end = div_q == DW'(CLK_DIV - 1);
        frame_end = half_end && ph_q == PH_LAST;
`ifdef TOUCH_AVG_EN
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        pairs_d = pairs_q;
        sum_x = acc_x_q + 14'(res_q);
        sum_y = acc_y_q + 14'(raw_y_q);
`endif
        case (state_q)
            IDLE: begin
                state_d = pen_s ? IDLE : SETTLE;
                cnt_d = '0;
            end
            SETTLE: begin
                state_d = pen_s ? IDLE : cnt_q == CW'(SETTLE_CYC - 1) ? FRAME_Y : SETTLE;
                tx_d = !pen_s && cnt_q == CW'(SETTLE_CYC - 1);
                cnt_d = cnt_q == CW'(SETTLE_CYC - 1) ? cnt_q : cnt_q + 1'b1;
            end
            FRAME_Y, FRAME_X: begin
                div_d = half_end ? '0 : div_q + 1'b1;
                ph_d = frame_end ? '0 : ph_q + 6'(half_end);
                if (frame_end && state_q == FRAME_Y) begin
                    state_d = FRAME_X;
                    raw_y_d = res_q;
                end
                if (frame_end && state_q == FRAME_X) begin
                    state_d = UPDATE;
                    tx_d = !pen_s;
                    if (!pen_s) begin
`ifdef TOUCH_AVG_EN
                        new_d = pairs_q == 2'd3;
                        x_d = new_d ? sum_x[13:6] : x_q;
                        y_d = new_d ? sum_y[13:6] : y_q;
                        acc_x_d = new_d ? '0 : sum_x;
                        acc_y_d = new_d ? '0 : sum_y;
                        pairs_d = pairs_q + 1'b1;
`else
                        new_d = 1'b1;
                        x_d = res_q[11:4];
                        y_d = raw_y_q[11:4];
`endif
                    end
                end
            end
            UPDATE: begin
                state_d = tx_q ? GAP : IDLE;
                cnt_d = '0;
            end
            GAP: begin
                state_d = pen_s ? IDLE : cnt_q == CW'(GAP_CYC - 1) ? FRAME_Y : GAP;
                tx_d = !pen_s;
                cnt_d = cnt_q == CW'(GAP_CYC - 1) ? cnt_q : cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
`ifdef TOUCH_AVG_EN
        if (!tx_d) begin
            acc_x_d = '0;
            acc_y_d = '0;
            pairs_d = '0;
        end
`endif
        in_frame_d = state_d == FRAME_Y || state_d == FRAME_X;
        bit_d = ph_d[5:1];
        cmd_d = state_d == FRAME_Y ? 8'h90 : 8'hD0;
        cs_n_d = !(in_frame_d && ph_d != PH_LAST);
        dclk_d = !cs_n_d && ph_d[0];
        din_d = !cs_n_d && bit_d < 5'd8 && cmd_d[~bit_d[2:0]];
        if (dclk_d && !dclk_q && bit_d >= 5'd9 && bit_d <= 5'd20)
            res_d = {res_q[10:0], dout_s};
    end
    always_ff @(posedge sys_clk) begin
        if (iRST) begin
            state_q <= IDLE;
            pen_sync_q <= 2'b11;
            dout_sync_q <= '0;
            cnt_q <= '0;
            div_q <= '0;
            ph_q <= '0;
            res_q <= '0;
            raw_y_q <= '0;
            cs_n_q <= 1'b1;
            dclk_q <= 1'b0;
            din_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            new_q <= 1'b0;
            tx_q <= 1'b0;
`ifdef TOUCH_AVG_EN
            acc_x_q <= '0;
            acc_y_q <= '0;
            pairs_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pen_sync_q <= {pen_sync_q[0], penirq_n};
            dout_sync_q <= {dout_sync_q[0], adc_dout};
            cnt_q <= cnt_d;
            div_q <= div_d;
            ph_q <= ph_d;
            res_q <= res_d;
            raw_y_q <= raw_y_d;
            cs_n_q <= cs_n_d;
            dclk_q <= dclk_d;
            din_q <= din_d;
            x_q <= x_d;
            y_q <= y_d;
            new_q <= new_d;
            tx_q <= tx_d;
`ifdef TOUCH_AVG_EN
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            pairs_q <= pairs_d;
`endif
        end
    end
    assign adc_cs_n = cs_n_q;
    assign adc_dclk = dclk_q;
    assign adc_din = din_q;
    assign x = x_q;
    assign y = y_q;
    assign new_coord_r = new_q;
    assign transmit_en = tx_q;
endmodule

// File: tb/tb_touch_adc_ctrl.sv
// tb_touch_adc_ctrl: randomized bench for touch_adc_ctrl with a behavioural ADS7843 model
`timescale 1ns/1ps
module tb_touch_adc_ctrl;
    logic sys_clk = 1'b0, iRST = 1'b1, penirq_n = 1'b1, adc_dout = 1'b0;
    logic adc_cs_n, adc_dclk, adc_din, new_coord_r, transmit_en;
    logic [7:0] x, y;
    int checks = 0, failures = 0;
    logic [11:0] x_raw = '0, y_raw = '0;
    logic [7:0] cmd_cap = '0;
    logic [7:0] cmd_log[$];
    int rises = 0, last_rises = 0, frames = 0, pulses = 0, dclk_bad = 0;
    touch_adc_ctrl #(.CLK_DIV(2), .SETTLE_CYC(8), .GAP_CYC(16)) dut (
        .sys_clk(sys_clk), .iRST(iRST), .penirq_n(penirq_n), .adc_dout(adc_dout),
        .adc_cs_n(adc_cs_n), .adc_dclk(adc_dclk), .adc_din(adc_din),
        .x(x), .y(y), .new_coord_r(new_coord_r), .transmit_en(transmit_en)
    );
    always #5 sys_clk = ~sys_clk;
    // ADC: latch command on DCLK rises 0-7, then present result bit n+1 right after rise n
    always @(negedge adc_cs_n or posedge adc_cs_n or posedge adc_dclk) begin
        logic [11:0] raw;
        if (adc_dclk === 1'b1) begin
            if (rises < 8) cmd_cap = {cmd_cap[6:0], adc_din};
            rises++;
            raw = (cmd_cap == 8'h90) ? y_raw : x_raw;
            adc_dout = (rises >= 9 && rises <= 20) ? raw[4'(20 - rises)] : 1'b0;
        end else if (adc_cs_n === 1'b0) begin
            rises = 0;
            cmd_cap = '0;
            frames++;
            adc_dout = 1'b0;
        end else if (adc_cs_n === 1'b1) begin
            last_rises = rises;
            cmd_log.push_back(cmd_cap);
            adc_dout = 1'b0;
        end
    end
    always @(negedge sys_clk) begin
        if (new_coord_r === 1'b1) pulses++;
        if (adc_cs_n === 1'b1 && adc_dclk !== 1'b0 && !iRST) dclk_bad++;
    end
    task automatic wait_cs(input logic lvl, input string name);
        logic prev;
        bit ok;
        prev = adc_cs_n;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge sys_clk);
            ok = (prev !== lvl) && (adc_cs_n === lvl);
            prev = adc_cs_n;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s timeout waiting cs_n=%b", name, lvl); end
    endtask
    task automatic wait_tx0(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge sys_clk);
            ok = transmit_en === 1'b0;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s transmit_en never fell", name); end
    endtask
    task automatic wait_pulse(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge sys_clk);
            ok = new_coord_r === 1'b1;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s no new_coord_r pulse", name); end
    endtask
    task automatic test_reset();
        iRST = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if ({adc_cs_n, adc_dclk, adc_din} !== 3'b100) begin
            failures++; $display("FAIL reset_pins got cs/dclk/din=%b%b%b exp=100", adc_cs_n, adc_dclk, adc_din);
        end
        checks++;
        if ({x, y} !== 16'h0) begin failures++; $display("FAIL reset_xy got=%h exp=0000", {x, y}); end
        checks++;
        if ({new_coord_r, transmit_en} !== 2'b00) begin
            failures++; $display("FAIL reset_flags got new/tx=%b%b exp=00", new_coord_r, transmit_en);
        end
        iRST = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask
    task automatic test_basic();
        int p0;
        x_raw = 12'h3C0;
        y_raw = 12'hA5F;
        cmd_log.delete();
        p0 = pulses;
        penirq_n = 1'b0;
        wait_cs(1'b1, "basic_y");
        checks++;
        if (transmit_en !== 1'b1) begin failures++; $display("FAIL basic_tx_on got=%b exp=1", transmit_en); end
        wait_cs(1'b1, "basic_x");
        @(negedge sys_clk);
        checks++;
        if ({new_coord_r, transmit_en} !== 2'b01) begin
            failures++; $display("FAIL basic_tail got new/tx=%b%b exp=01", new_coord_r, transmit_en);
        end
        @(negedge sys_clk);
        checks++;
        if (new_coord_r !== 1'b1) begin failures++; $display("FAIL basic_pulse got=%b exp=1", new_coord_r); end
        checks++;
        if (x !== 8'h3C || y !== 8'hA5) begin failures++; $display("FAIL basic_xy got x=%h y=%h exp x=3c y=a5", x, y); end
        @(negedge sys_clk);
        checks++;
        if (new_coord_r !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", new_coord_r); end
        checks++;
        if (cmd_log.size() != 2 || cmd_log[0] !== 8'h90 || cmd_log[1] !== 8'hD0) begin
            failures++; $display("FAIL basic_cmds got n=%0d first=%h exp 90,d0", cmd_log.size(), cmd_log.size() > 0 ? cmd_log[0] : 8'h00);
        end
        checks++;
        if (last_rises != 24) begin failures++; $display("FAIL basic_dclk_count got=%0d exp=24", last_rises); end
        penirq_n = 1'b1;
        wait_tx0("basic_release");
        repeat (40) @(negedge sys_clk);
        #1;
        checks++;
        if (pulses - p0 != 1) begin failures++; $display("FAIL basic_pulse_count got=%0d exp=1", pulses - p0); end
    endtask
    task automatic test_short_pen();
        int f0, low, txs;
        f0 = frames;
        low = 0;
        txs = 0;
        penirq_n = 1'b0;
        repeat (5) @(negedge sys_clk);
        penirq_n = 1'b1;
        repeat (60) begin
            @(negedge sys_clk);
            if (adc_cs_n !== 1'b1) low++;
            if (transmit_en !== 1'b0) txs++;
        end
        checks++;
        if (low != 0 || frames != f0) begin failures++; $display("FAIL short_no_frame got cs_low=%0d frames=%0d exp 0,0", low, frames - f0); end
        checks++;
        if (txs != 0) begin failures++; $display("FAIL short_tx got high_cycles=%0d exp=0", txs); end
    endtask
    task automatic test_release_mid_x();
        logic [7:0] x0, y0;
        int p0, f0;
        x0 = x;
        y0 = y;
        p0 = pulses;
        f0 = frames;
        x_raw = 12'($urandom);
        y_raw = 12'($urandom);
        penirq_n = 1'b0;
        wait_cs(1'b1, "rel_y");
        wait_cs(1'b0, "rel_x_start");
        repeat (10) @(negedge sys_clk);
        penirq_n = 1'b1;
        wait_cs(1'b1, "rel_x_end");
        @(negedge sys_clk);
        checks++;
        if (transmit_en !== 1'b1) begin failures++; $display("FAIL rel_tx_tail got=%b exp=1", transmit_en); end
        @(negedge sys_clk);
        checks++;
        if ({new_coord_r, transmit_en} !== 2'b00) begin
            failures++; $display("FAIL rel_update got new/tx=%b%b exp=00", new_coord_r, transmit_en);
        end
        repeat (150) @(negedge sys_clk);
        #1;
        checks++;
        if (x !== x0 || y !== y0) begin failures++; $display("FAIL rel_xy_kept got x=%h y=%h exp x=%h y=%h", x, y, x0, y0); end
        checks++;
        if (pulses != p0 || frames - f0 != 2) begin
            failures++; $display("FAIL rel_activity got pulses=%0d frames=%0d exp 0,2", pulses - p0, frames - f0);
        end
    endtask
    task automatic test_random();
        logic [11:0] xr, yr;
        for (int s = 0; s < 4; s++) begin
            penirq_n = 1'b0;
            for (int p = 0; p < 2; p++) begin
                xr = 12'($urandom_range(12'hFFF, 12'h100));
                yr = 12'($urandom_range(12'hFFF, 12'h100));
                x_raw = xr;
                y_raw = yr;
                wait_pulse("rand_pulse");
                checks++;
                if (x !== xr[11:4] || y !== yr[11:4]) begin
                    failures++; $display("FAIL rand_xy s=%0d p=%0d got x=%h y=%h exp x=%h y=%h", s, p, x, y, xr[11:4], yr[11:4]);
                end
                checks++;
                if (transmit_en !== 1'b1) begin failures++; $display("FAIL rand_tx got=%b exp=1", transmit_en); end
            end
            penirq_n = 1'b1;
            wait_tx0("rand_release");
            repeat (20) @(negedge sys_clk);
        end
    endtask
    task automatic test_reset_mid_frame();
        bit ok;
        int p0;
        x_raw = 12'($urandom);
        y_raw = 12'($urandom);
        penirq_n = 1'b0;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge sys_clk);
            ok = adc_cs_n === 1'b0 && rises >= 12;
        end
        checks++;
        if (!ok || cmd_cap !== 8'h90) begin failures++; $display("FAIL rstmid_reach got ok=%0d cmd=%h exp 1,90", ok, cmd_cap); end
        iRST = 1'b1;
        @(negedge sys_clk);
        checks++;
        if ({adc_cs_n, adc_dclk, adc_din} !== 3'b100) begin
            failures++; $display("FAIL rstmid_pins got cs/dclk/din=%b%b%b exp=100", adc_cs_n, adc_dclk, adc_din);
        end
        checks++;
        if ({x, y, new_coord_r, transmit_en} !== 18'h0) begin
            failures++; $display("FAIL rstmid_outs got x=%h y=%h new=%b tx=%b exp all 0", x, y, new_coord_r, transmit_en);
        end
        penirq_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        iRST = 1'b0;
        p0 = pulses;
        repeat (300) @(negedge sys_clk);
        #1;
        checks++;
        if (pulses != p0 || adc_cs_n !== 1'b1) begin failures++; $display("FAIL rstmid_quiet got pulses=%0d cs=%b exp 0,1", pulses - p0, adc_cs_n); end
    endtask
`ifdef TOUCH_AVG_EN
    task automatic test_avg();
        logic [11:0] xs[4];
        logic [11:0] ys[4];
        int sx, sy, p0;
        xs[0] = 12'h100; xs[1] = 12'h200; xs[2] = 12'h300; xs[3] = 12'h400;
        sx = 0;
        sy = 0;
        p0 = pulses;
        penirq_n = 1'b0;
        for (int p = 0; p < 4; p++) begin
            ys[p] = 12'($urandom);
            x_raw = xs[p];
            y_raw = ys[p];
            sx += int'(xs[p]);
            sy += int'(ys[p]);
            wait_cs(1'b1, "avg_y");
            wait_cs(1'b1, "avg_x");
        end
        repeat (2) @(negedge sys_clk);
        checks++;
        if (new_coord_r !== 1'b1 || x !== 8'(sx >> 6) || y !== 8'(sy >> 6)) begin
            failures++; $display("FAIL avg_publish got new=%b x=%h y=%h exp 1 x=%h y=%h", new_coord_r, x, y, 8'(sx >> 6), 8'(sy >> 6));
        end
        #1;
        checks++;
        if (pulses - p0 != 1) begin failures++; $display("FAIL avg_count got=%0d exp=1", pulses - p0); end
        penirq_n = 1'b1;
        wait_tx0("avg_release");
        repeat (20) @(negedge sys_clk);
        p0 = pulses;
        penirq_n = 1'b0;
        repeat (4) wait_cs(1'b1, "avg_partial");
        penirq_n = 1'b1;
        wait_tx0("avg_partial_release");
        repeat (300) @(negedge sys_clk);
        #1;
        checks++;
        if (pulses != p0) begin failures++; $display("FAIL avg_partial got pulses=%0d exp=0", pulses - p0); end
    endtask
`endif
    initial begin
        test_reset();
`ifndef TOUCH_AVG_EN
        test_basic();
`endif
        test_short_pen();
`ifndef TOUCH_AVG_EN
        test_release_mid_x();
        test_random();
`endif
        test_reset_mid_frame();
`ifdef TOUCH_AVG_EN
        test_avg();
`endif
        checks++;
        if (dclk_bad != 0) begin failures++; $display("FAIL dclk_idle got=%0d exp=0", dclk_bad); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
